// File: rtl/hazard_scoreboard.sv
`default_nettype none
// ============================================================================
// Module   : hazard_scoreboard
// Brief    : In-order pipeline RAW hazard scoreboard. Tracks the destination
//            registers of the DEPTH post-ID stages (EX .. WB), picks forwarding
//            sources for the ID operands, raises load-use / RAW stalls and
//            turns EX-resolved redirects into IF/ID flushes. Carries
//            saturating stall and flush performance counters.
// Revision : 1.0 - initial release
// ============================================================================
module hazard_scoreboard #(
  parameter  int DEPTH     = 3,  // tracked stages, entry 0 = EX, DEPTH-1 = WB
  parameter  int FWD_EN    = 1,  // 1: forward, stall on load-use only; 0: stall on RAW
  parameter  int RF_BYPASS = 1,  // 1: register file returns same-cycle WB data
  localparam int SW        = $clog2(DEPTH + 1)
) (
  input  logic          i_clk,
  input  logic          i_reset,
  input  logic          id_vld,
  input  logic [4:0]    id_rs1,
  input  logic [4:0]    id_rs2,
  input  logic          id_rs1_used,
  input  logic          id_rs2_used,
  input  logic [4:0]    id_rd,
  input  logic          id_rd_wren,
  input  logic          id_is_load,
  input  logic          ex_redirect,
  output logic          stall,
  output logic          flush_if,
  output logic          flush_id,
  output logic [SW-1:0] fwd_rs1_sel,
  output logic [SW-1:0] fwd_rs2_sel,
  output logic [31:0]   stall_cnt,
  output logic [31:0]   flush_cnt
);

  localparam logic [SW-1:0] C_WB_IDX = SW'(DEPTH - 1);

  // Scoreboard entries, one per post-ID stage
  logic [DEPTH-1:0] vld_q,  vld_d;
  logic [DEPTH-1:0] wren_q, wren_d;
  logic [DEPTH-1:0] ld_q,   ld_d;
  logic [4:0]       rd_q [DEPTH];
  logic [4:0]       rd_d [DEPTH];

  logic [31:0]      stall_cnt_q, stall_cnt_d;
  logic [31:0]      flush_cnt_q, flush_cnt_d;

  // Per-source youngest-match results
  logic [4:0]       src_addr [2];
  logic [1:0]       src_used;
  logic [1:0]       src_hit;
  logic [SW-1:0]    src_idx  [2];
  logic [SW-1:0]    src_sel  [2];
  logic [1:0]       src_haz;

  // Youngest matching entry per source: scan oldest to youngest so the
  // lowest index written last wins.
  always_comb begin
    src_addr[0] = id_rs1;
    src_addr[1] = id_rs2;
    src_used[0] = id_rs1_used;
    src_used[1] = id_rs2_used;
    for (int j = 0; j < 2; j++) begin
      src_hit[j] = 1'b0;
      src_idx[j] = '0;
      for (int k = DEPTH - 1; k >= 0; k--) begin
        if (src_used[j] && (src_addr[j] != 5'd0) && vld_q[k] && wren_q[k] &&
            (rd_q[k] == src_addr[j])) begin
          src_hit[j] = 1'b1;
          src_idx[j] = SW'(k);
        end
      end
    end
  end

  // Hazard and forward-select decision per source, from the mode parameters
  always_comb begin
    for (int j = 0; j < 2; j++) begin
      src_haz[j] = 1'b0;
      src_sel[j] = '0;
      if (src_hit[j]) begin
        if (FWD_EN != 0) begin
          // Only a load still in EX cannot be forwarded in time
          src_haz[j] = (src_idx[j] == '0) && ld_q[0];
          if (!((RF_BYPASS != 0) && (src_idx[j] == C_WB_IDX))) begin
            src_sel[j] = src_idx[j] + SW'(1);
          end
        end else begin
          // Without forwarding every in-flight producer stalls, except a WB
          // producer whose data the register file already bypasses
          src_haz[j] = !((RF_BYPASS != 0) && (src_idx[j] == C_WB_IDX));
        end
      end
    end
  end

  // Control outputs: redirect outranks stall; nothing flushes during reset
  always_comb begin
    stall       = id_vld && (|src_haz) && !ex_redirect;
    flush_if    = ex_redirect && !i_reset;
    flush_id    = ex_redirect && !i_reset;
    fwd_rs1_sel = src_sel[0];
    fwd_rs2_sel = src_sel[1];
    stall_cnt   = stall_cnt_q;
    flush_cnt   = flush_cnt_q;
  end

  // Next-state: advance the shift register, bubble into EX on stall/redirect,
  // saturating counters
  always_comb begin
    if (stall || ex_redirect) begin
      vld_d[0]  = 1'b0;
      wren_d[0] = 1'b0;
      ld_d[0]   = 1'b0;
      rd_d[0]   = 5'd0;
    end else begin
      vld_d[0]  = id_vld;
      wren_d[0] = id_rd_wren;
      ld_d[0]   = id_is_load;
      rd_d[0]   = id_rd;
    end
    for (int k = 1; k < DEPTH; k++) begin
      vld_d[k]  = vld_q[k-1];
      wren_d[k] = wren_q[k-1];
      ld_d[k]   = ld_q[k-1];
      rd_d[k]   = rd_q[k-1];
    end
    stall_cnt_d = stall_cnt_q;
    if (stall && (stall_cnt_q != 32'hFFFF_FFFF)) begin
      stall_cnt_d = stall_cnt_q + 32'd1;
    end
    flush_cnt_d = flush_cnt_q;
    if (ex_redirect && (flush_cnt_q != 32'hFFFF_FFFF)) begin
      flush_cnt_d = flush_cnt_q + 32'd1;
    end
  end

  // State registers; reset empties the scoreboard without waiting for a clock
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      vld_q       <= '0;
      wren_q      <= '0;
      ld_q        <= '0;
      for (int k = 0; k < DEPTH; k++) begin
        rd_q[k] <= 5'd0;
      end
      stall_cnt_q <= 32'd0;
      flush_cnt_q <= 32'd0;
    end else begin
      vld_q       <= vld_d;
      wren_q      <= wren_d;
      ld_q        <= ld_d;
      for (int k = 0; k < DEPTH; k++) begin
        rd_q[k] <= rd_d[k];
      end
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

endmodule
`default_nettype wire

// File: doc/hazard_scoreboard.md
HAZARD_SCOREBOARD -- requirements
Module: hazard_scoreboard

Interface
REQ-001 Parameter DEPTH, default 3, SHALL set the number of tracked post-ID stages; entry 0 = EX, entry DEPTH-1 = WB, legal range 2..8.
REQ-002 Parameter FWD_EN, default 1, SHALL select the mode: 1 = forwarding with load-use stall only; 0 = stall on any RAW hazard.
REQ-003 Parameter RF_BYPASS, default 1, SHALL indicate the register file returns same-cycle WB write data on read, so WB-entry matches need no action.
REQ-004 Localparam SW SHALL equal $clog2(DEPTH+1).
REQ-005 i_clk  in  1  sole clock, rising edge.
REQ-006 i_reset  in  1  asynchronous, active-high reset.
REQ-007 id_vld  in  1  ID holds a valid instruction.
REQ-008 id_rs1, id_rs2  in  5 each  source register addresses.
REQ-009 id_rs1_used, id_rs2_used  in  1 each  source is actually read.
REQ-010 id_rd  in  5  destination register address.
REQ-011 id_rd_wren  in  1  instruction writes rd.
REQ-012 id_is_load  in  1  instruction is a load.
REQ-013 ex_redirect  in  1  taken branch/jump resolved in EX this cycle.
REQ-014 stall  out  1  hold PC and IF/ID; insert bubble into EX.
REQ-015 flush_if, flush_id  out  1 each  clear IF/ID and ID/EX registers.
REQ-016 fwd_rs1_sel, fwd_rs2_sel  out  SW each  0 = register file, k+1 = result of entry k.
REQ-017 stall_cnt, flush_cnt  out  32 each  performance counters.

Function
REQ-018 The block SHALL hold a shift register of DEPTH entries {vld, rd, wren, is_load}.
REQ-019 Per cycle, entry k SHALL move to entry k+1, and the entry in DEPTH-1 SHALL retire.
REQ-020 Entry 0 SHALL load the ID fields with vld=id_vld, unless stall or ex_redirect is high, in which case it SHALL load a bubble (all zero).
REQ-021 A source SHALL match entry k when the source is used, rs != 0, and entry k has vld=1, wren=1 and rd=rs.
REQ-022 The lowest-index (youngest) match SHALL win.
REQ-023 FWD_EN=1: stall SHALL be high when a source's youngest match is entry 0 with is_load=1.
REQ-024 FWD_EN=1: fwd_sel SHALL be k+1 for a youngest match at entry k, except a WB-entry match with RF_BYPASS=1, which SHALL give 0.
REQ-025 FWD_EN=0: stall SHALL be high on any match, excluding entry DEPTH-1 when RF_BYPASS=1, and fwd_sel SHALL be 0.
REQ-026 stall and fwd_sel SHALL be combinational, with 0 latency from the ID inputs.
REQ-027 stall SHALL be gated by id_vld.
REQ-028 When ex_redirect=1, stall SHALL be forced to 0 and flush_if=flush_id=1 in the same cycle; redirect has priority over stall.
REQ-029 flush_if and flush_id SHALL otherwise be 0.
REQ-030 stall_cnt SHALL increment on each cycle where the output stall=1.
REQ-031 flush_cnt SHALL increment on each cycle where ex_redirect=1.
REQ-032 Both counters SHALL saturate at 0xFFFFFFFF and never wrap.
REQ-033 A multi-cycle stall SHALL repeat each cycle until the producing entry advances past the hazard window; no cycle cap.

Reset
REQ-034 While i_reset=1, all entries SHALL clear to vld=0 immediately, with no clock required.
REQ-035 While i_reset=1, stall_cnt and flush_cnt SHALL be 0.
REQ-036 While i_reset=1 and id_vld=0, stall, flush_if, flush_id and fwd_sel SHALL be 0.
REQ-037 A reset asserted mid-stall SHALL drop stall as soon as the entries clear, and the first cycle after release SHALL see an empty scoreboard.

Verification
REQ-038 FWD_EN=1: lw x5, then add x6,x5,x1 in ID next cycle -> stall=1 for exactly 1 cycle; then fwd_rs1_sel=2 (MEM), fwd_rs2_sel=0; stall_cnt=1.
REQ-039 FWD_EN=1: addi x7 followed by sub x8,x7,x7 -> stall=0, fwd_rs1_sel=fwd_rs2_sel=1.
REQ-040 FWD_EN=0, RF_BYPASS=1, DEPTH=3: addi x3 then a dependent use -> stall=1 for 2 cycles, release when producer reaches WB, fwd_sel=0.
REQ-041 Load-use hazard present and ex_redirect=1 in the same cycle -> stall=0, flush_if=flush_id=1, entry 0 bubble, flush_cnt=1.
REQ-042 Source x0 with rd=x0 load in EX -> stall=0, fwd_sel=0.
REQ-043 Force stall_cnt to 0xFFFFFFFE, apply 3 stall cycles -> stall_cnt=0xFFFFFFFF; then assert i_reset -> counters 0 before the next clock edge.
